// File: rtl/uart_8.sv
`default_nettype none
// ============================================================================
// Module   : uart_8
// Purpose  : 8N1 UART with an oversampled receiver and an optional
//            transmitter (built only when UART8_TX_EN is defined).
// Revision : 1.0
// ============================================================================
module uart_8 #(
    parameter int CLOCK_RATE = 12000000,
    parameter int BAUD_RATE  = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rxEn,
    input  logic       rxIn,
    output logic       rxBusy,
    output logic       rxDone,
    output logic       rxErr,
    output logic [7:0] rxOut,
    input  logic       txEn,
    input  logic       txStart,
    input  logic [7:0] txIn,
    output logic       txBusy,
    output logic       txDone,
    output logic       txOut
);

    localparam int RX_DIV = CLOCK_RATE / (BAUD_RATE * OVERSAMPLE);
    localparam int RX_CW  = (RX_DIV > 1) ? $clog2(RX_DIV) : 1;
    localparam int OS_CW  = $clog2(OVERSAMPLE);

    localparam logic [RX_CW-1:0] RX_DIV_LAST  = RX_CW'(RX_DIV - 1);
    localparam logic [OS_CW-1:0] OS_LAST      = OS_CW'(OVERSAMPLE - 1);
    localparam logic [OS_CW-1:0] OS_HALF_LAST = OS_CW'(OVERSAMPLE / 2 - 1);

    localparam logic [2:0] RX_IDLE  = 3'd0;
    localparam logic [2:0] RX_START = 3'd1;
    localparam logic [2:0] RX_DATA  = 3'd2;
    localparam logic [2:0] RX_STOP  = 3'd3;
    localparam logic [2:0] RX_ERROR = 3'd4;

    logic             rx_meta_q,  rx_meta_d;
    logic             rx_sync_q,  rx_sync_d;
    logic [RX_CW-1:0] rx_div_q,   rx_div_d;
    logic [2:0]       rx_state_q, rx_state_d;
    logic [OS_CW-1:0] rx_os_q,    rx_os_d;
    logic [2:0]       rx_bit_q,   rx_bit_d;
    logic [7:0]       rx_shift_q, rx_shift_d;
    logic [7:0]       rx_out_q,   rx_out_d;
    logic             rx_done_q,  rx_done_d;
    logic             rx_err_q,   rx_err_d;
    logic             rx_tick;

    always_comb begin
        rx_tick    = (rx_div_q == RX_DIV_LAST);
        rx_div_d   = rx_tick ? '0 : rx_div_q + 1'b1;
        rx_meta_d  = rxIn;
        rx_sync_d  = rx_meta_q;
        rx_state_d = rx_state_q;
        rx_os_d    = rx_os_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_out_d   = rx_out_q;
        rx_done_d  = 1'b0;
        rx_err_d   = rx_err_q;

        if (!rxEn) begin
            rx_state_d = RX_IDLE;
            rx_os_d    = '0;
            rx_err_d   = 1'b0;
        end else if (rx_tick) begin
            case (rx_state_q)
                RX_IDLE: begin
                    if (!rx_sync_q) begin
                        rx_state_d = RX_START;
                        rx_os_d    = '0;
                    end
                end
                RX_START: begin
                    // Half a bit in: a high line here was only a glitch.
                    if (rx_os_q == OS_HALF_LAST) begin
                        rx_os_d    = '0;
                        rx_bit_d   = '0;
                        rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_os_d = rx_os_q + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (rx_os_q == OS_LAST) begin
                        rx_os_d    = '0;
                        rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                        rx_bit_d   = rx_bit_q + 1'b1;
                        if (rx_bit_q == 3'd7) begin
                            rx_state_d = RX_STOP;
                        end
                    end else begin
                        rx_os_d = rx_os_q + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (rx_os_q == OS_LAST) begin
                        rx_os_d = '0;
                        if (rx_sync_q) begin
                            rx_out_d   = rx_shift_q;
                            rx_done_d  = 1'b1;
                            rx_state_d = RX_IDLE;
                        end else begin
                            rx_err_d   = 1'b1;
                            rx_state_d = RX_ERROR;
                        end
                    end else begin
                        rx_os_d = rx_os_q + 1'b1;
                    end
                end
                RX_ERROR: begin
                    if (rx_sync_q) begin
                        rx_err_d   = 1'b0;
                        rx_state_d = RX_IDLE;
                    end
                end
                default: rx_state_d = RX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_div_q   <= '0;
            rx_state_q <= RX_IDLE;
            rx_os_q    <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_out_q   <= '0;
            rx_done_q  <= 1'b0;
            rx_err_q   <= 1'b0;
        end else begin
            rx_meta_q  <= rx_meta_d;
            rx_sync_q  <= rx_sync_d;
            rx_div_q   <= rx_div_d;
            rx_state_q <= rx_state_d;
            rx_os_q    <= rx_os_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_out_q   <= rx_out_d;
            rx_done_q  <= rx_done_d;
            rx_err_q   <= rx_err_d;
        end
    end

    assign rxBusy = (rx_state_q == RX_START) || (rx_state_q == RX_DATA) ||
                    (rx_state_q == RX_STOP);
    assign rxDone = rx_done_q;
    assign rxErr  = rx_err_q;
    assign rxOut  = rx_out_q;

`ifdef UART8_TX_EN
    localparam int TX_DIV = CLOCK_RATE / BAUD_RATE;
    localparam int TX_CW  = (TX_DIV > 1) ? $clog2(TX_DIV) : 1;
    localparam logic [TX_CW-1:0] TX_DIV_LAST = TX_CW'(TX_DIV - 1);

    localparam logic [1:0] TX_IDLE  = 2'd0;
    localparam logic [1:0] TX_START = 2'd1;
    localparam logic [1:0] TX_DATA  = 2'd2;
    localparam logic [1:0] TX_STOP  = 2'd3;

    logic [1:0]       tx_state_q, tx_state_d;
    logic [TX_CW-1:0] tx_cnt_q,   tx_cnt_d;
    logic [2:0]       tx_bit_q,   tx_bit_d;
    logic [7:0]       tx_shift_q, tx_shift_d;
    logic             tx_out_q,   tx_out_d;
    logic             tx_done_q,  tx_done_d;
    logic             tx_tick;

    always_comb begin
        tx_tick    = (tx_cnt_q == TX_DIV_LAST);
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_tick ? '0 : tx_cnt_q + 1'b1;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_out_d   = tx_out_q;
        tx_done_d  = 1'b0;

        if (!txEn) begin
            tx_state_d = TX_IDLE;
            tx_cnt_d   = '0;
            tx_out_d   = 1'b1;
        end else begin
            case (tx_state_q)
                TX_IDLE: begin
                    tx_cnt_d = '0;
                    tx_out_d = 1'b1;
                    if (txStart) begin
                        tx_shift_d = txIn;
                        tx_state_d = TX_START;
                        tx_out_d   = 1'b0;
                    end
                end
                TX_START: begin
                    if (tx_tick) begin
                        tx_state_d = TX_DATA;
                        tx_bit_d   = '0;
                        tx_out_d   = tx_shift_q[0];
                    end
                end
                TX_DATA: begin
                    if (tx_tick) begin
                        if (tx_bit_q == 3'd7) begin
                            tx_state_d = TX_STOP;
                            tx_out_d   = 1'b1;
                        end else begin
                            tx_bit_d   = tx_bit_q + 1'b1;
                            tx_shift_d = {1'b0, tx_shift_q[7:1]};
                            tx_out_d   = tx_shift_q[1];
                        end
                    end
                end
                default: begin
                    if (tx_tick) begin
                        tx_state_d = TX_IDLE;
                        tx_done_d  = 1'b1;
                        tx_out_d   = 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_out_q   <= 1'b1;
            tx_done_q  <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_out_q   <= tx_out_d;
            tx_done_q  <= tx_done_d;
        end
    end

    assign txBusy = (tx_state_q != TX_IDLE);
    assign txDone = tx_done_q;
    assign txOut  = tx_out_q;
`else
    logic unused_tx;
    assign unused_tx = ^{txEn, txStart, txIn};
    assign txBusy    = 1'b0;
    assign txDone    = 1'b0;
    assign txOut     = 1'b1;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_8.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_8
// Purpose  : Scoreboard bench for uart_8 at default parameters.
// Revision : 1.0
// ============================================================================
module tb_uart_8;

    logic       clk = 1'b0;
    logic       reset, rxEn, rxIn, txEn, txStart;
    logic [7:0] txIn;
    logic       rxBusy, rxDone, rxErr, txBusy, txDone, txOut;
    logic [7:0] rxOut;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int rx_start_cyc = 0;
    int rx_done_cyc  = 0;
    bit tx_mon_off   = 1'b0;

    logic [7:0] rx_exp_q[$];
    logic       tx_exp_q[$];

    uart_8 dut (
        .clk     (clk),
        .reset   (reset),
        .rxEn    (rxEn),
        .rxIn    (rxIn),
        .rxBusy  (rxBusy),
        .rxDone  (rxDone),
        .rxErr   (rxErr),
        .rxOut   (rxOut),
        .txEn    (txEn),
        .txStart (txStart),
        .txIn    (txIn),
        .txBusy  (txBusy),
        .txDone  (txDone),
        .txOut   (txOut)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_rx(input logic [7:0] b, input int bclk, input bit stop_hi);
        rxIn = 1'b0;
        rx_start_cyc = cyc;
        tick(bclk);
        for (int i = 0; i < 8; i++) begin
            rxIn = b[i];
            tick(bclk);
        end
        rxIn = stop_hi;
        if (stop_hi) tick(bclk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rxBusy"}, rxBusy, 1'b0);
        check({tag, "_rxDone"}, rxDone, 1'b0);
        check({tag, "_rxErr"},  rxErr,  1'b0);
        check({tag, "_rxOut"},  rxOut,  8'h00);
        check({tag, "_txBusy"}, txBusy, 1'b0);
        check({tag, "_txDone"}, txDone, 1'b0);
        check({tag, "_txOut"},  txOut,  1'b1);
    endtask

    // Receive monitor: every rxDone must match the oldest expected byte.
    initial begin : rx_mon
        logic prev;
        logic [7:0] exp;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rxDone) begin
                check("rx_done_expected", rx_exp_q.size() > 0, 1'b1);
                check("rx_done_one_clk", prev, 1'b0);
                if (rx_exp_q.size() > 0) begin
                    exp = rx_exp_q.pop_front();
                    check("rx_byte", rxOut, exp);
                end
                check("rx_err_on_done", rxErr, 1'b0);
                rx_done_cyc = cyc;
            end
            prev = rxDone;
        end
    end

    // Transmit monitor: checks first and last clk of every bit, then txDone.
    initial begin : tx_mon
        logic prev;
        logic expb;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (txBusy && !prev && !tx_mon_off) begin
                check("tx_frame_expected", tx_exp_q.size(), 10);
                for (int k = 0; k < 10; k++) begin
                    expb = (tx_exp_q.size() > 0) ? tx_exp_q.pop_front() : 1'b1;
                    check("tx_bit_first", txOut, expb);
                    repeat (1249) @(negedge clk);
                    check("tx_bit_last", txOut, expb);
                    if (k == 9) check("tx_busy_last", txBusy, 1'b1);
                    @(negedge clk);
                end
                check("tx_busy_end", txBusy, 1'b0);
                check("tx_done_pulse", txDone, 1'b1);
                @(negedge clk);
                check("tx_done_one_clk", txDone, 1'b0);
            end
            prev = txBusy;
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int         w;
        int         cnt;
        logic [9:0] tx_pat;

        reset = 1'b1; rxEn = 1'b0; rxIn = 1'b1;
        txEn = 1'b0; txStart = 1'b0; txIn = 8'h00;
        tick(4);
        @(negedge clk);
        check_reset_outputs("reset");
        tick(1);
        reset = 1'b0; rxEn = 1'b1; txEn = 1'b1;
        tick(20);

        // Nominal 0xD5 receive, full duplex with a 0xA3 transmit.
        rx_exp_q.push_back(8'hD5);
        fork
            send_rx(8'hD5, 1250, 1'b1);
            begin
                tick(150);
                check("rx_busy_on_start", rxBusy, 1'b1);
            end
            begin
`ifdef UART8_TX_EN
                tx_pat = 10'b1101000110;
                for (int i = 0; i < 10; i++) tx_exp_q.push_back(tx_pat[i]);
                txIn = 8'hA3; txStart = 1'b1;
                tick(1);
                txStart = 1'b0;
                tick(4000);
                txIn = 8'hFF; txStart = 1'b1;
                tick(1);
                txStart = 1'b0;
                tick(8650);
                check("tx_all_bits_seen", tx_exp_q.size(), 0);
                check("tx_idle_after", txBusy, 1'b0);
                check("tx_line_idle", txOut, 1'b1);
`else
                tx_pat = 10'b0;
                txIn = 8'hA3; txStart = 1'b1;
                tick(1);
                txStart = 1'b0;
                tick(5);
                check("tx_tied_busy", txBusy | tx_pat[0], 1'b0);
                check("tx_tied_done", txDone, 1'b0);
                check("tx_tied_out", txOut, 1'b1);
`endif
            end
        join
        tick(100);
        check("rx_nominal_seen", rx_exp_q.size(), 0);
        check("rx_latency_ok", (rx_done_cyc - rx_start_cyc >= 11800) &&
                               (rx_done_cyc - rx_start_cyc <= 12000), 1'b1);
        check("rx_idle_after", rxBusy, 1'b0);
        check("rx_no_err", rxErr, 1'b0);

        // Framing error: line stays low where the stop bit belongs.
        send_rx(8'hD5, 1250, 1'b0);
        w = 0;
        while (rxErr !== 1'b1 && w < 1200) begin
            tick(1);
            w++;
        end
        check("rx_err_set", rxErr, 1'b1);
        check("rx_err_timing", (w >= 550) && (w <= 750), 1'b1);
        check("rx_err_out_kept", rxOut, 8'hD5);
        tick(1500);
        check("rx_err_held", rxErr, 1'b1);
        check("rx_err_no_restart", rxBusy, 1'b0);
        rxIn = 1'b1;
        tick(200);
        check("rx_err_cleared", rxErr, 1'b0);
        tick(100);

        // Baud mismatch of about 3% in each direction.
        rx_exp_q.push_back(8'hD5);
        send_rx(8'hD5, 1290, 1'b1);
        tick(100);
        check("rx_slow_seen", rx_exp_q.size(), 0);
        rx_exp_q.push_back(8'hD5);
        send_rx(8'hD5, 1212, 1'b1);
        tick(100);
        check("rx_fast_seen", rx_exp_q.size(), 0);
        check("rx_mismatch_no_err", rxErr, 1'b0);

        // 20 us glitch on an idle line.
        cnt = 0;
        for (int i = 0; i < 1500; i++) begin
            if (i == 0)   rxIn = 1'b0;
            if (i == 240) rxIn = 1'b1;
            @(negedge clk);
            if (rxBusy) cnt++;
        end
        check("rx_glitch_busy_len", (cnt >= 600) && (cnt <= 625), 1'b1);
        check("rx_glitch_no_err", rxErr, 1'b0);
        tick(50);

        // Receiver disable aborts a frame in progress.
        rxIn = 1'b0; tick(1250);
        rxIn = 1'b1; tick(1250);
        rxIn = 1'b0; tick(600);
        check("rx_busy_before_abort", rxBusy, 1'b1);
        rxEn = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rx_abort_busy", rxBusy, 1'b0);
        check("rx_abort_err", rxErr, 1'b0);
        check("rx_abort_out_kept", rxOut, 8'hD5);
        rxIn = 1'b1;
        tick(100);
        rxEn = 1'b1;
        tick(100);

        // Reset during rx bit 3 and tx bit 3.
        tx_mon_off = 1'b1;
        rxIn = 1'b0; txIn = 8'h5A; txStart = 1'b1;
        tick(1);
        txStart = 1'b0;
        tick(1249); rxIn = 1'b1;
        tick(1250); rxIn = 1'b0;
        tick(1250); rxIn = 1'b1;
        tick(1250); rxIn = 1'b0;
        tick(600);
        check("rx_busy_before_reset", rxBusy, 1'b1);
`ifdef UART8_TX_EN
        check("tx_busy_before_reset", txBusy, 1'b1);
`endif
        reset = 1'b1; rxIn = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_reset_outputs("midframe_reset");
        tick(1);
        reset = 1'b0;
        tick(200);
        check("post_reset_rx_idle", rxBusy, 1'b0);
        check("rx_queue_empty", rx_exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
